// File: rtl/wb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// wb_sdram_arbiter
//
// Two-master Wishbone B4 pipelined arbiter in front of the SDRAM controller
// slave port. Master 0 is the USB ingress path (SDRAM writes), master 1 is
// the USB egress path (SDRAM reads). Everything runs in the USB_IFCLK domain.
//
// Handshake: a request is accepted on a clock edge where s_stb_o=1 and
// s_stall_i=0. Each accepted request is later closed by exactly one s_ack_i.
// Master-side stall/ack/data are combinational passthroughs of the slave
// signals (zero added latency); the slave-side request is a combinational
// mux of the current owner's request.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   m0_* / m1_*                  Wishbone master ports (cyc/stb/we/sel/addr/
//                                data in; data/stall/ack/err out)
//   s_*                          Wishbone port towards the SDRAM controller
//   dbg_state                    FSM state (0 IDLE, 1 GRANT, 2 ABORT)
//   dbg_outstanding              accepted-but-unacked request count
//
// Build option: define WB_ARB_ROUND_ROBIN_EN to break simultaneous requests
// in favour of the master that was not granted last; otherwise master 0
// always wins a tie.
// ---------------------------------------------------------------------------
module wb_sdram_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_sel_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_stall_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_sel_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_stall_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [3:0]            s_sel_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_stall_i,
    input  logic                  s_ack_i,

    output logic [1:0]            dbg_state,
    output logic [3:0]            dbg_outstanding
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    localparam logic [3:0] MAX_OUT     = 4'(MAX_OUTSTANDING);
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    state_t     state;
    logic       owner;        // 0 = master 0, 1 = master 1
    logic [3:0] outstanding;
    logic [7:0] timeout;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic       last_owner;
`endif

    // Owner request mux
    logic                  own_cyc;
    logic                  own_stb;
    logic                  own_we;
    logic [3:0]            own_sel;
    logic [ADDR_WIDTH-1:0] own_addr;
    logic [DATA_WIDTH-1:0] own_data;

    always_comb begin
        own_cyc  = m0_cyc_i;
        own_stb  = m0_stb_i;
        own_we   = m0_we_i;
        own_sel  = m0_sel_i;
        own_addr = m0_addr_i;
        own_data = m0_data_i;
        if (owner) begin
            own_cyc  = m1_cyc_i;
            own_stb  = m1_stb_i;
            own_we   = m1_we_i;
            own_sel  = m1_sel_i;
            own_addr = m1_addr_i;
            own_data = m1_data_i;
        end
    end

    logic granted;
    logic room;
    logic full;
    logic timed_out;
    logic ack_ok;
    logic accept;
    logic next_owner;

    assign granted   = (state == ST_GRANT);
    assign room      = (outstanding < MAX_OUT);
    assign full      = (outstanding == MAX_OUT);
    assign timed_out = granted && (timeout == TIMEOUT_LIM);
    // Acks with nothing outstanding (stale or spurious) are swallowed.
    assign ack_ok    = granted && s_ack_i && (outstanding != 4'd0);
    assign accept    = s_stb_o && !s_stall_i;

`ifdef WB_ARB_ROUND_ROBIN_EN
    assign next_owner = (m0_cyc_i && m1_cyc_i) ? ~last_owner : ~m0_cyc_i;
`else
    // Master 0 wins whenever it is requesting.
    assign next_owner = ~m0_cyc_i;
`endif

    // Slave request outputs are quiet outside GRANT.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_addr_o = '0;
        s_data_o = '0;
        if (granted) begin
            s_cyc_o  = own_cyc;
            s_stb_o  = own_stb && room;
            s_we_o   = own_we;
            s_sel_o  = own_sel;
            s_addr_o = own_addr;
            s_data_o = own_data;
        end
    end

    // A master is only released from stall while it owns the bus in GRANT.
    assign m0_stall_o = !(granted && !owner) || s_stall_i || full;
    assign m1_stall_o = !(granted &&  owner) || s_stall_i || full;
    assign m0_ack_o   = ack_ok && !owner;
    assign m1_ack_o   = ack_ok &&  owner;
    assign m0_err_o   = timed_out && !owner;
    assign m1_err_o   = timed_out &&  owner;
    assign m0_data_o  = s_data_i;
    assign m1_data_o  = s_data_i;

    assign dbg_state       = state;
    assign dbg_outstanding = outstanding;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            outstanding <= 4'd0;
            timeout     <= 8'd0;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_owner  <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    outstanding <= 4'd0;
                    timeout     <= 8'd0;
                    if (m0_cyc_i || m1_cyc_i) begin
                        state <= ST_GRANT;
                        owner <= next_owner;
`ifdef WB_ARB_ROUND_ROBIN_EN
                        last_owner <= next_owner;
`endif
                    end
                end
                ST_GRANT: begin
                    if (timed_out) begin
                        // Hung slave: give up on everything in flight.
                        state       <= ST_ABORT;
                        outstanding <= 4'd0;
                        timeout     <= 8'd0;
                    end else if (!own_cyc) begin
                        state       <= ST_IDLE;
                        outstanding <= 4'd0;
                        timeout     <= 8'd0;
                    end else begin
                        case ({accept, ack_ok})
                            2'b10:   outstanding <= outstanding + 4'd1;
                            2'b01:   outstanding <= outstanding - 4'd1;
                            default: outstanding <= outstanding;
                        endcase
                        if (ack_ok || (outstanding == 4'd0)) begin
                            timeout <= 8'd0;
                        end else begin
                            timeout <= timeout + 8'd1;
                        end
                    end
                end
                ST_ABORT: begin
                    if (!own_cyc) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_sdram_arbiter
//
// Directed bench for wb_sdram_arbiter with default parameters
// (MAX_OUTSTANDING=4, TIMEOUT_CYCLES=255). Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_wb_sdram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          m0_cyc, m0_stb, m0_we;
    logic [3:0]    m0_sel;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m0_stall, m0_ack, m0_err;

    logic          m1_cyc, m1_stb, m1_we;
    logic [3:0]    m1_sel;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          m1_stall, m1_ack, m1_err;

    logic          s_cyc, s_stb, s_we;
    logic [3:0]    s_sel;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic          s_stall, s_ack;

    logic [1:0]    dbg_state;
    logic [3:0]    dbg_outstanding;

    wb_sdram_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .m0_cyc_i       (m0_cyc),
        .m0_stb_i       (m0_stb),
        .m0_we_i        (m0_we),
        .m0_sel_i       (m0_sel),
        .m0_addr_i      (m0_addr),
        .m0_data_i      (m0_wdata),
        .m0_data_o      (m0_rdata),
        .m0_stall_o     (m0_stall),
        .m0_ack_o       (m0_ack),
        .m0_err_o       (m0_err),
        .m1_cyc_i       (m1_cyc),
        .m1_stb_i       (m1_stb),
        .m1_we_i        (m1_we),
        .m1_sel_i       (m1_sel),
        .m1_addr_i      (m1_addr),
        .m1_data_i      (m1_wdata),
        .m1_data_o      (m1_rdata),
        .m1_stall_o     (m1_stall),
        .m1_ack_o       (m1_ack),
        .m1_err_o       (m1_err),
        .s_cyc_o        (s_cyc),
        .s_stb_o        (s_stb),
        .s_we_o         (s_we),
        .s_sel_o        (s_sel),
        .s_addr_o       (s_addr),
        .s_data_o       (s_wdata),
        .s_data_i       (s_rdata),
        .s_stall_i      (s_stall),
        .s_ack_i        (s_ack),
        .dbg_state      (dbg_state),
        .dbg_outstanding(dbg_outstanding)
    );

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'h0; m0_addr = '0; m0_wdata = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'h0; m1_addr = '0; m1_wdata = '0;
        s_stall = 0; s_ack = 0; s_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    // Expected per-cycle behaviour for six pipelined reads by master 1
    // (cycle 0 is the grant cycle; slave withholds acks until cycle 7).
    bit t4_stb[14]   = '{0,1,1,1,1,1,1,1,1,1,0,0,0,0};
    bit t4_ack[14]   = '{0,0,0,0,0,0,0,1,1,1,1,1,1,0};
    bit t4_stall[14] = '{0,0,0,0,0,1,1,1,0,0,0,0,0,0};
    bit t4_sstb[14]  = '{0,1,1,1,1,0,0,0,1,1,0,0,0,0};
    int t4_out[14]   = '{0,0,1,2,3,4,4,4,3,3,3,2,1,0};

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int req;
        int acks_sent;
        int k;
        logic exp_owner;

        idle_inputs();
        rst = 1;
        repeat (2) step();

        // ---- reset state ----
        mid();
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_out", dbg_outstanding, 0);
        check("rst_scyc", s_cyc, 0);
        check("rst_sstb", s_stb, 0);
        check("rst_m0_stall", m0_stall, 1);
        check("rst_m1_stall", m1_stall, 1);
        check("rst_acks", {m0_ack, m1_ack}, 0);
        check("rst_errs", {m0_err, m1_err}, 0);
        rst = 0;
        step();

        // ---- m0 writes 0x100..0x102, slave acks two cycles after each accept ----
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hf; m0_addr = 32'h100; m0_wdata = 32'hA0;
        mid();
        check("t2_scyc_c0", s_cyc, 0);
        check("t2_saddr_idle", s_addr, 0);
        step();
        mid();
        check("t2_scyc_c1", s_cyc, 1);
        check("t2_sstb_c1", s_stb, 1);
        check("t2_saddr_c1", s_addr, 32'h100);
        check("t2_swe_c1", s_we, 1);
        check("t2_ssel_c1", s_sel, 4'hf);
        check("t2_sdata_c1", s_wdata, 32'hA0);
        check("t2_m0_stall_c1", m0_stall, 0);
        check("t2_m1_stall_c1", m1_stall, 1);
        step();
        m0_addr = 32'h101; m0_wdata = 32'hA1;
        mid();
        check("t2_out_c2", dbg_outstanding, 1);
        check("t2_saddr_c2", s_addr, 32'h101);
        check("t2_m0_ack_c2", m0_ack, 0);
        step();
        m0_addr = 32'h102; m0_wdata = 32'hA2; s_ack = 1;
        mid();
        check("t2_out_c3", dbg_outstanding, 2);
        check("t2_m0_ack_c3", m0_ack, 1);
        check("t2_m1_ack_c3", m1_ack, 0);
        check("t2_m1_stall_c3", m1_stall, 1);
        step();
        m0_stb = 0;
        mid();
        check("t2_out_c4", dbg_outstanding, 2);
        check("t2_m0_ack_c4", m0_ack, 1);
        check("t2_sstb_c4", s_stb, 0);
        step();
        mid();
        check("t2_out_c5", dbg_outstanding, 1);
        check("t2_m0_ack_c5", m0_ack, 1);
        check("t2_m1_stall_c5", m1_stall, 1);
        step();
        s_ack = 0;
        mid();
        check("t2_out_c6", dbg_outstanding, 0);
        check("t2_m0_ack_c6", m0_ack, 0);
        m0_cyc = 0;
        step();
        mid();
        check("t2_state_end", dbg_state, ST_IDLE);
        check("t2_scyc_end", s_cyc, 0);

        // ---- simultaneous requests twice, starting from reset ----
        do_reset();
        m0_cyc = 1; m1_cyc = 1; m0_stb = 0; m1_stb = 0;
        mid();
        check("t3_scyc_req", s_cyc, 0);
        step();
        mid();
        check("t3_state_g1", dbg_state, ST_GRANT);
        check("t3_m0_stall_g1", m0_stall, 0);
        check("t3_m1_stall_g1", m1_stall, 1);
        m0_cyc = 0; m1_cyc = 0;
        step();
        mid();
        check("t3_state_dead", dbg_state, ST_IDLE);
        check("t3_scyc_dead", s_cyc, 0);
        m0_cyc = 1; m1_cyc = 1;
        step();
`ifdef WB_ARB_ROUND_ROBIN_EN
        exp_owner = 1'b1;
`else
        exp_owner = 1'b0;
`endif
        mid();
        check("t3_scyc_g2", s_cyc, 1);
        check("t3_m0_stall_g2", m0_stall, exp_owner);
        check("t3_m1_stall_g2", m1_stall, !exp_owner);
        m0_cyc = 0; m1_cyc = 0;
        step();

        // ---- m1 issues six reads, slave withholds acks then returns them ----
        for (int i = 0; i < 6; i++) exp_q.push_back(32'hDA7A_0000 + DW'(i));
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_sel = 4'hf; m1_addr = 32'h200;
        req = 0;
        acks_sent = 0;
        step();
        for (int c = 1; c < 14; c++) begin
            m1_stb  = t4_stb[c];
            m1_addr = 32'h200 + AW'(req);
            s_ack   = t4_ack[c];
            s_rdata = t4_ack[c] ? 32'hDA7A_0000 + DW'(acks_sent) : 32'h0;
            mid();
            check($sformatf("t4_out_c%0d", c), dbg_outstanding, t4_out[c]);
            check($sformatf("t4_stall_c%0d", c), m1_stall, t4_stall[c]);
            check($sformatf("t4_sstb_c%0d", c), s_stb, t4_sstb[c]);
            check($sformatf("t4_ack_c%0d", c), m1_ack, t4_ack[c]);
            check($sformatf("t4_m0_ack_c%0d", c), m0_ack, 0);
            if (t4_sstb[c]) check($sformatf("t4_addr_c%0d", c), s_addr, 32'h200 + AW'(req));
            if (t4_ack[c]) begin
                check($sformatf("t4_rdata_c%0d", c), m1_rdata, exp_q.pop_front());
                acks_sent++;
            end
            if (t4_sstb[c]) req++;
            step();
        end
        check("t4_queue_empty", exp_q.size(), 0);
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        step();

        // ---- stray acks and same-cycle accept+ack ----
        s_ack = 1;
        mid();
        check("t5_idle_m0_ack", m0_ack, 0);
        check("t5_idle_m1_ack", m1_ack, 0);
        m0_cyc = 1; m0_stb = 0; m0_we = 1; m0_addr = 32'h300;
        step();
        mid();
        check("t5_grant_state", dbg_state, ST_GRANT);
        check("t5_zero_out_ack", m0_ack, 0);
        check("t5_out_zero", dbg_outstanding, 0);
        s_ack = 0; m0_stb = 1;
        step();
        m0_stb = 1; s_ack = 1; m0_addr = 32'h301;
        mid();
        check("t5_out_before", dbg_outstanding, 1);
        check("t5_ack_fwd", m0_ack, 1);
        step();
        m0_stb = 0;
        mid();
        check("t5_out_same_cycle", dbg_outstanding, 1);
        step();
        s_ack = 0;
        mid();
        check("t5_out_drained", dbg_outstanding, 0);
        m0_cyc = 0;
        step();

        // ---- timeout: one accepted request that is never acked ----
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h400;
        step();
        step();
        m0_stb = 0;
        mid();
        check("t6_out_one", dbg_outstanding, 1);
        k = 0;
        while (m0_err !== 1'b1 && k < 300) begin
            step();
            mid();
            k++;
        end
        check("t6_timeout_cycles", k, 255);
        check("t6_m1_err", m1_err, 0);
        step();
        mid();
        check("t6_state_abort", dbg_state, ST_ABORT);
        check("t6_scyc_abort", s_cyc, 0);
        check("t6_err_once", m0_err, 0);
        check("t6_m0_stall_abort", m0_stall, 1);
        check("t6_out_cleared", dbg_outstanding, 0);
        step();
        mid();
        check("t6_abort_hold", dbg_state, ST_ABORT);
        m0_cyc = 0;
        step();
        mid();
        check("t6_state_idle", dbg_state, ST_IDLE);

        // ---- reset with two reads outstanding ----
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_addr = 32'h500;
        step();
        step();
        m1_addr = 32'h501;
        step();
        m1_stb = 0;
        mid();
        check("t7_out_two", dbg_outstanding, 2);
        rst = 1;
        step();
        rst = 0; m1_cyc = 0; s_ack = 1;
        mid();
        check("t7_state", dbg_state, ST_IDLE);
        check("t7_scyc", s_cyc, 0);
        check("t7_out", dbg_outstanding, 0);
        check("t7_late_ack", m1_ack, 0);
        step();
        s_ack = 0;
        mid();
        check("t7_stay_idle", dbg_state, ST_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_sdram_arbiter.md
# wb_sdram_arbiter

Two-master Wishbone B4 pipelined arbiter that shares the single SDRAM controller Wishbone slave port between the USB ingress path (master 0, SDRAM writes) and the USB egress path (master 1, SDRAM reads). It sits between the USB FIFO state machines and the `sdram` instance, in the `USB_IFCLK` domain. It owns grant sequencing, ack/stall routing, outstanding-request tracking, a bounded outstanding limit and an ack timeout that aborts a hung cycle.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width on all ports
- `DATA_WIDTH`, 32, data width on all ports; select width is fixed at 4
- `MAX_OUTSTANDING`, 4, accepted-but-unacked requests allowed per grant (1..15)
- `TIMEOUT_CYCLES`, 255, cycles without ack (while outstanding > 0) before abort (1..255)

Ports (x = 0, 1). One clock; reset is synchronous and active-high:
- `clk_i`  in  1  system clock (driven by `USB_IFCLK`)
- `rst_i`  in  1  synchronous active-high reset
- `mx_cyc_i`, `mx_stb_i`, `mx_we_i`  in  1 each  master x cycle, strobe, write enable
- `mx_sel_i`  in  4  master x byte select
- `mx_addr_i`  in  ADDR_WIDTH  master x address
- `mx_data_i`  in  DATA_WIDTH  master x write data
- `mx_data_o`  out  DATA_WIDTH  read data (slave data, broadcast to both)
- `mx_stall_o`  out  1  stall to master x
- `mx_ack_o`  out  1  ack to master x
- `mx_err_o`  out  1  one-cycle timeout abort pulse to master x
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  to slave
- `s_sel_o`  out  4;  `s_addr_o`  out  ADDR_WIDTH;  `s_data_o`  out  DATA_WIDTH
- `s_data_i`  in  DATA_WIDTH;  `s_stall_i`, `s_ack_i`  in  1 each

## Operation
- States: IDLE, GRANT (owner register 0/1), ABORT.
- IDLE: s_cyc_o=0, s_stb_o=0, both stall_o=1. If any `mx_cyc_i`=1, register owner and go to GRANT. Single requester wins. Tie: see Configuration.
- GRANT: slave request outputs mux from the owner. `s_cyc_o`=owner cyc. `s_stb_o`=owner stb AND (outstanding < MAX_OUTSTANDING). Owner `stall_o` = `s_stall_i` OR (outstanding == MAX_OUTSTANDING). Non-owner `stall_o`=1, ack=0.
- Accept = s_stb_o & ~s_stall_i. Outstanding counter (4 bits): +1 on accept, −1 on `s_ack_i` when outstanding > 0. Accept and ack in the same cycle leave it unchanged.
- `s_ack_i` with outstanding == 0, or in IDLE/ABORT: ignored and not forwarded.
- Owner ack_o = `s_ack_i` while in GRANT with outstanding > 0.
- Owner drops cyc: go to IDLE next edge and clear outstanding. Late acks are then dropped.
- Timeout counter (8 bits): clears on ack or when outstanding == 0, otherwise increments. When it reaches TIMEOUT_CYCLES, pulse owner `err_o` for 1 cycle, clear outstanding, and go to ABORT.
- ABORT: s_cyc_o=0, owner stall_o=1. Return to IDLE on the first cycle the owner cyc is low.
- Reset: state=IDLE, outstanding=0, timeout=0, last-owner=1. All s_* request outputs are 0; stall_o=1, ack_o=0, err_o=0.

## Timing
- Grant latency: a request in IDLE at edge N is visible on s_cyc_o after edge N+1.
- Release: owner cyc low at edge N means IDLE after N+1, so the earliest other grant is after edge N+2 (one dead cycle between owners).
- Request path IDLE→slave is combinational through the owner mux. Ack, stall and data are combinational passthrough (zero added latency).
- Reset mid-cycle: all state cleared at the next edge. Acks in flight are dropped.

## Configuration
- `WB_ARB_ROUND_ROBIN_EN` defined: a tie in IDLE is granted to the master that is not the last owner. The last-owner register updates on every grant.
- Not defined: fixed priority, master 0 always wins ties. The last-owner register is not implemented.

## Test plan
- Reset, then m0 writes 3 words to addr 0x100..0x102 with slave stall 0 and ack 2 cycles later → s_cyc_o rises 1 cycle after m0_cyc_i, m0_ack_o pulses 3 times, m1_stall_o=1 throughout.
- Both cyc raised on the same cycle, twice in succession → with macro: m0 then m1 granted, one dead cycle between. Without macro: m0 both times.
- m1 issues 6 back-to-back reads, slave withholds ack → m1_stall_o=1 once outstanding=4. After acks resume, all 6 acks arrive in order with s_data_i passed through.
- Slave never acks 1 accepted request, TIMEOUT_CYCLES=255 → m0_err_o pulses 255 cycles after acceptance, s_cyc_o=0 next cycle, and IDLE is reached after m0 drops cyc.
- Stray s_ack_i in IDLE and an accept+ack in the same cycle → no ack forwarded in IDLE. Outstanding is unchanged in the same-cycle case.
- rst_i asserted for 1 cycle with 2 requests outstanding → next cycle: state IDLE, s_cyc_o=0, a subsequent ack is not forwarded.
